// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch (I) and data load/store (D)
// share a single memory port. One transaction at a time, round-robin on ties,
// registered memory strobes, and a watchdog that aborts unanswered transactions.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // A zero-width counter is illegal, so keep one bit when the watchdog is disabled.
  localparam int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_WIDTH-1:0]  wd_cnt_q, wd_cnt_d;
  logic                  timeout_err_q, timeout_err_d;

  logic busy;
  logic expire;
  logic done;
  logic d_pend;
  logic pick_d;

  assign busy   = (state_q != IDLE);
  // Expiry is the cycle in which the count would reach TIMEOUT; a mem_resp in the
  // same cycle wins and completes normally.
  assign expire = (TIMEOUT != 0) && busy && !mem_resp && (wd_cnt_q == CNT_LAST);
  assign done   = busy && (mem_resp || expire);

  // On a tie, grant whoever did not win last time.
  assign d_pend = d_read | d_write;
  assign pick_d = d_pend && (!i_read || (last_grant_q == GRANT_I));

  // Completion pulses and read data; data is forced to zero on a watchdog abort.
  always_comb begin
    i_resp  = (state_q == BUSY_I) && done;
    d_resp  = (state_q == BUSY_D) && done;
    i_rdata = ((state_q == BUSY_I) && expire) ? '0 : mem_rdata;
    d_rdata = ((state_q == BUSY_D) && expire) ? '0 : mem_rdata;
  end

  // Next-state: grant from IDLE, retire on response or watchdog expiry.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q | expire;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          // Write takes precedence when both are set.
          mem_write_d  = d_write;
          mem_read_d   = d_read & ~d_write;
          wd_cnt_d     = '0;
        end else if (i_read) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          mem_addr_d   = i_addr;
          mem_write_d  = 1'b0;
          mem_read_d   = 1'b1;
          wd_cnt_d     = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else if (TIMEOUT != 0) begin
          wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State registers; reset kills any transaction in flight without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  // The flag is visible in the expiry cycle itself and then held by the register.
  assign timeout_err = timeout_err_q | expire;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a delayed-response memory device plus a
// transaction-level reference model (round-robin owner, reference memory contents).
module tb_mem_port_arbiter;

  localparam int DELAY = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hA5A5A5A5;
  logic        mem_resp = 1'b0;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: who won the last grant (0=I, 1=D) and expected memory.
  bit          last_m = 1'b0;
  logic [31:0] ref_mem [logic [31:0]];

  // Memory device state.
  logic [31:0] dev_mem [logic [31:0]];
  bit          mem_mute = 1'b0;
  int          dcnt = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory device: answers with a one-cycle mem_resp in the DELAY-th strobe cycle.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_resp = 1'b0;
      dcnt = 0;
    end else if (mem_resp) begin
      mem_resp = 1'b0;
      dcnt = 0;
    end else if (mem_read || mem_write) begin
      if (mem_mute) begin
        mem_rdata = 32'hA5A5A5A5;
      end else begin
        dcnt++;
        if (dcnt == DELAY) begin
          mem_resp = 1'b1;
          if (mem_write) dev_mem[mem_addr] = mem_wdata;
          else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : ~mem_addr;
        end
      end
    end else begin
      dcnt = 0;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  // One round: I and/or D present a request together; each is dropped at its resp.
  task automatic run_round(input bit use_i, input bit use_d, input bit d_wr, input bit d_rd,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] dw);
    bit first_d, cur_d, got_i, got_d, seen_first, first_was_d;
    int n;
    logic [31:0] exp_i, exp_d;
    first_d = (use_i && use_d) ? (last_m == 1'b0) : use_d;
    cur_d = first_d;
    exp_i = ref_rd(ia);
    exp_d = ref_rd(da);
    seen_first = 1'b0;
    first_was_d = 1'b0;
    @(posedge clk); #1;
    i_read = use_i; i_addr = ia;
    d_read = use_d & d_rd; d_write = use_d & d_wr; d_addr = da; d_wdata = dw;
    got_i = !use_i; got_d = !use_d; n = 0;
    while (!(got_i && got_d) && n < 100) begin
      @(negedge clk); n++;
      if (n == 2) begin
        n_checks++;
        if (!(mem_read || mem_write)) $display("FAIL grant_latency: strobe=%b required 1", 1'b0);
        else n_pass++;
      end
      if (mem_read || mem_write) begin
        n_checks++;
        if (mem_addr !== (cur_d ? da : ia) || mem_write !== (cur_d && d_wr) ||
            mem_read !== !(cur_d && d_wr))
          $display("FAIL strobe: addr=%h rd=%b wr=%b required addr=%h wr=%b",
                   mem_addr, mem_read, mem_write, cur_d ? da : ia, cur_d && d_wr);
        else n_pass++;
      end
      n_checks++;
      if ((i_resp && (cur_d || got_i)) || (d_resp && (!cur_d || got_d)))
        $display("FAIL stray_resp: i_resp=%b d_resp=%b owner_d=%b", i_resp, d_resp, cur_d);
      else n_pass++;
      if (i_resp && !cur_d && !got_i) begin
        n_checks++;
        if (i_rdata !== exp_i) $display("FAIL i_rdata: got %h required %h", i_rdata, exp_i);
        else n_pass++;
        if (!seen_first) begin seen_first = 1'b1; first_was_d = 1'b0; end
        got_i = 1'b1; cur_d = 1'b1;
      end else if (d_resp && cur_d && !got_d) begin
        if (!d_wr) begin
          n_checks++;
          if (d_rdata !== exp_d) $display("FAIL d_rdata: got %h required %h", d_rdata, exp_d);
          else n_pass++;
        end
        if (!seen_first) begin seen_first = 1'b1; first_was_d = 1'b1; end
        got_d = 1'b1; cur_d = 1'b0;
      end
      @(posedge clk); #1;
      if (got_i) i_read = 1'b0;
      if (got_d) begin d_read = 1'b0; d_write = 1'b0; end
    end
    n_checks++;
    if (n >= 100) $display("FAIL round_timeout: cycles=%0d required <100", n);
    else n_pass++;
    n_checks++;
    if (first_was_d !== first_d) $display("FAIL grant_order: first_d=%b required %b",
                                          first_was_d, first_d);
    else n_pass++;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if (use_d && d_wr) ref_mem[da] = dw;
    last_m = (use_i && use_d) ? !first_d : use_d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_read, mem_write, timeout_err, i_resp, d_resp} !== 5'b0)
      $display("FAIL reset_ctrl: rd/wr/err/iresp/dresp=%b required 00000",
               {mem_read, mem_write, timeout_err, i_resp, d_resp});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_data: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    else n_pass++;
    rst = 1'b0;
    last_m = 1'b0;
  endtask

  task automatic test_single_fetch();
    dev_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
  endtask

  task automatic test_write_readback();
    run_round(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h200, 32'h12345678);
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0);
  endtask

  task automatic test_write_precedence();
    run_round(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h240, 32'hCAFEF00D);
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h240, 32'h0);
  endtask

  // Both requesters held continuously from reset: D, I, D, I with 2-cycle gaps.
  task automatic test_back_to_back();
    int cyc, k, resp_cyc, nresp;
    bit prev;
    test_reset();
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 32'h300; d_read = 1'b1; d_addr = 32'h400;
    cyc = 0; k = 0; resp_cyc = 0; nresp = 0; prev = 1'b0;
    while (nresp < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (mem_read && !prev) begin
        n_checks++;
        if ((mem_addr == 32'h400) !== (k % 2 == 0))
          $display("FAIL b2b_order: grant %0d addr=%h required %h", k, mem_addr,
                   (k % 2 == 0) ? 32'h400 : 32'h300);
        else n_pass++;
        n_checks++;
        if (cyc - resp_cyc !== 2)
          $display("FAIL b2b_gap: grant %0d gap=%0d required 2", k, cyc - resp_cyc);
        else n_pass++;
        k++;
      end
      prev = mem_read;
      if (i_resp || d_resp) begin resp_cyc = cyc; nresp++; end
    end
    n_checks++;
    if (nresp != 4) $display("FAIL b2b_timeout: resps=%0d required 4", nresp);
    else n_pass++;
    @(posedge clk); #1;
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(posedge clk);
    last_m = 1'b0;
  endtask

  // Memory never answers: abort on the TMO-th busy cycle with zeroed data.
  task automatic test_watchdog();
    int busy_n, n;
    bit hit;
    mem_mute = 1'b1;
    @(posedge clk); #1;
    d_read = 1'b1; d_addr = 32'h600;
    busy_n = 0; n = 0; hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk); n++;
      if (mem_read) busy_n++;
      if (d_resp) begin
        hit = 1'b1;
        n_checks++;
        if (busy_n !== TMO) $display("FAIL wd_cycle: busy=%0d required %0d", busy_n, TMO);
        else n_pass++;
        n_checks++;
        if (d_rdata !== 32'h0) $display("FAIL wd_rdata: got %h required 0", d_rdata);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1) $display("FAIL wd_err: got %b required 1", timeout_err);
        else n_pass++;
      end
    end
    n_checks++;
    if (!hit) $display("FAIL wd_no_abort: cycles=%0d required abort", n);
    else n_pass++;
    @(posedge clk); #1;
    d_read = 1'b0;
    mem_mute = 1'b0;
    last_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (timeout_err !== 1'b1 || mem_read !== 1'b0)
      $display("FAIL wd_sticky: err=%b rd=%b required 1 0", timeout_err, mem_read);
    else n_pass++;
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0);
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL wd_sticky2: got %b required 1", timeout_err);
    else n_pass++;
  endtask

  // Asynchronous reset in the middle of a fetch.
  task automatic test_async_reset();
    bit stray;
    test_reset();
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 32'h500;
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (mem_read !== 1'b1) $display("FAIL ar_pre: mem_read=%b required 1", mem_read);
    else n_pass++;
    rst = 1'b1; i_read = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b0) $display("FAIL ar_drop: mem_read=%b required 0", mem_read);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = 1'b0;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (i_resp || d_resp || mem_read) stray = 1'b1;
    end
    n_checks++;
    if (stray) $display("FAIL ar_stray: activity=%b required 0", stray);
    else n_pass++;
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0);
    run_round(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h200, 32'h0);
  endtask

  task automatic test_random();
    bit ui, ud, wr, rd;
    logic [31:0] ia, da, dw;
    for (int r = 0; r < 30; r++) begin
      ui = $urandom_range(0, 1);
      ud = ui ? 1'($urandom_range(0, 1)) : 1'b1;
      wr = $urandom_range(0, 1);
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      ia = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      da = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      dw = $urandom;
      run_round(ui, ud, wr, rd, ia, da, dw);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_readback();
    test_write_precedence();
    test_back_to_back();
    test_random();
    test_watchdog();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
